axi4lite_responder: RTL and testbench

AXI4-Lite subordinate that terminates an AXI4-Lite bus and converts each transaction into a level-handshaked simple register bus (wr/wrDone, rd/rdDone). It is the responder end of the simple-bus-to-AXI manager used in our benches. It lets peripheral register files (SPI, ADC/DAC control) sit behind a plain request/done interface. Write and read paths are independent and may be active concurrently.

---
 rtl/axi4lite_responder.sv | 215 +++++++++++++++++++++
 tb/tb_axi4lite_responder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_responder.sv
// AXI4-Lite subordinate that turns each AXI transaction into a level-handshaked
// local register request (wr/wrDone, rd/rdDone); write and read paths run independently.
module axi4lite_responder #(
   parameter int C_S_AXI_ADDR_WIDTH = 14,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES     = 256
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic [C_S_AXI_ADDR_WIDTH-1:0]     wrAddr,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     wrData,
   output logic [C_S_AXI_DATA_WIDTH/8-1:0]   wrStrb,
   output logic                              wr,
   input  logic                              wrDone,
   output logic [C_S_AXI_ADDR_WIDTH-1:0]     rdAddr,
   output logic                              rd,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     rdData,
   input  logic                              rdDone
);

   localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
   localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP} r_state_t;

   // ---------------- write path ----------------
   w_state_t                      w_state_reg;
   logic                          aw_held_reg, w_held_reg;
   logic                          awready_reg, wready_reg, bvalid_reg;
   logic [1:0]                    bresp_reg;
   logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr_reg;
   logic [C_S_AXI_DATA_WIDTH-1:0] wr_data_reg;
   logic [STRB_W-1:0]             wr_strb_reg;
   logic                          wr_reg;
   logic [CNT_W-1:0]              w_cnt_reg;

   logic aw_fire, w_fire, aw_have, w_have, w_timeout;

   // Ready is only ever high in W_IDLE, so a fire implies the idle state.
   assign aw_fire   = S_AXI_AWVALID & awready_reg;
   assign w_fire    = S_AXI_WVALID & wready_reg;
   assign aw_have   = aw_held_reg | aw_fire;
   assign w_have    = w_held_reg | w_fire;
   assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_reg == CNT_LIMIT);

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         w_state_reg <= W_IDLE;
         aw_held_reg <= 1'b0;
         w_held_reg  <= 1'b0;
         awready_reg <= 1'b0;
         wready_reg  <= 1'b0;
         bvalid_reg  <= 1'b0;
         bresp_reg   <= RESP_OKAY;
         wr_addr_reg <= '0;
         wr_data_reg <= '0;
         wr_strb_reg <= '0;
         wr_reg      <= 1'b0;
         w_cnt_reg   <= '0;
      end else begin
         case (w_state_reg)
            W_IDLE: begin
               if (aw_fire) wr_addr_reg <= S_AXI_AWADDR;
               if (w_fire) begin
                  wr_data_reg <= S_AXI_WDATA;
                  wr_strb_reg <= S_AXI_WSTRB;
               end
               if (aw_have && w_have) begin
                  w_state_reg <= W_REQ;
                  wr_reg      <= 1'b1;
                  w_cnt_reg   <= '0;
                  aw_held_reg <= 1'b0;
                  w_held_reg  <= 1'b0;
                  awready_reg <= 1'b0;
                  wready_reg  <= 1'b0;
               end else begin
                  // Each channel is accepted once; its ready stays low until the pair completes.
                  aw_held_reg <= aw_have;
                  w_held_reg  <= w_have;
                  awready_reg <= ~aw_have;
                  wready_reg  <= ~w_have;
               end
            end
            W_REQ: begin
               if (wrDone) begin
                  wr_reg      <= 1'b0;
                  bvalid_reg  <= 1'b1;
                  bresp_reg   <= RESP_OKAY;
                  w_state_reg <= W_RESP;
               end else if (w_timeout) begin
                  wr_reg      <= 1'b0;
                  bvalid_reg  <= 1'b1;
                  bresp_reg   <= RESP_SLVERR;
                  w_state_reg <= W_RESP;
               end else if (w_cnt_reg != CNT_LIMIT) begin
                  w_cnt_reg <= w_cnt_reg + CNT_ONE;
               end
            end
            W_RESP: begin
               if (S_AXI_BREADY) begin
                  bvalid_reg  <= 1'b0;
                  awready_reg <= 1'b1;
                  wready_reg  <= 1'b1;
                  w_state_reg <= W_IDLE;
               end
            end
            default: w_state_reg <= W_IDLE;
         endcase
      end
   end

   // ---------------- read path ----------------
   r_state_t                      r_state_reg;
   logic                          arready_reg, rvalid_reg;
   logic [1:0]                    rresp_reg;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata_reg;
   logic [C_S_AXI_ADDR_WIDTH-1:0] rd_addr_reg;
   logic                          rd_reg;
   logic [CNT_W-1:0]              r_cnt_reg;

   logic ar_fire, r_timeout;

   assign ar_fire   = S_AXI_ARVALID & arready_reg;
   assign r_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt_reg == CNT_LIMIT);

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         r_state_reg <= R_IDLE;
         arready_reg <= 1'b0;
         rvalid_reg  <= 1'b0;
         rresp_reg   <= RESP_OKAY;
         rdata_reg   <= '0;
         rd_addr_reg <= '0;
         rd_reg      <= 1'b0;
         r_cnt_reg   <= '0;
      end else begin
         case (r_state_reg)
            R_IDLE: begin
               if (ar_fire) begin
                  rd_addr_reg <= S_AXI_ARADDR;
                  rd_reg      <= 1'b1;
                  r_cnt_reg   <= '0;
                  arready_reg <= 1'b0;
                  r_state_reg <= R_REQ;
               end else begin
                  arready_reg <= 1'b1;
               end
            end
            R_REQ: begin
               if (rdDone) begin
                  rd_reg      <= 1'b0;
                  rvalid_reg  <= 1'b1;
                  rdata_reg   <= rdData;
                  rresp_reg   <= RESP_OKAY;
                  r_state_reg <= R_RESP;
               end else if (r_timeout) begin
                  rd_reg      <= 1'b0;
                  rvalid_reg  <= 1'b1;
                  rdata_reg   <= '0;
                  rresp_reg   <= RESP_SLVERR;
                  r_state_reg <= R_RESP;
               end else if (r_cnt_reg != CNT_LIMIT) begin
                  r_cnt_reg <= r_cnt_reg + CNT_ONE;
               end
            end
            R_RESP: begin
               if (S_AXI_RREADY) begin
                  rvalid_reg  <= 1'b0;
                  arready_reg <= 1'b1;
                  r_state_reg <= R_IDLE;
               end
            end
            default: r_state_reg <= R_IDLE;
         endcase
      end
   end

   assign S_AXI_AWREADY = awready_reg;
   assign S_AXI_WREADY  = wready_reg;
   assign S_AXI_BVALID  = bvalid_reg;
   assign S_AXI_BRESP   = bresp_reg;
   assign S_AXI_ARREADY = arready_reg;
   assign S_AXI_RVALID  = rvalid_reg;
   assign S_AXI_RRESP   = rresp_reg;
   assign S_AXI_RDATA   = rdata_reg;
   assign wrAddr        = wr_addr_reg;
   assign wrData        = wr_data_reg;
   assign wrStrb        = wr_strb_reg;
   assign wr            = wr_reg;
   assign rdAddr        = rd_addr_reg;
   assign rd            = rd_reg;

endmodule

// File: tb/tb_axi4lite_responder.sv
// Directed bench for axi4lite_responder: stimulus pushes expectations into queues,
// independent monitors pop and compare when the DUT presents requests/responses.
module tb_axi4lite_responder;
   localparam int AW = 14, DW = 32, SW = 4, TO = 8;

   logic clk = 1'b0, rst = 1'b1;
   logic [AW-1:0] S_AXI_AWADDR = '0;  logic S_AXI_AWVALID = 1'b0; logic S_AXI_AWREADY;
   logic [DW-1:0] S_AXI_WDATA = '0;   logic [SW-1:0] S_AXI_WSTRB = '0;
   logic S_AXI_WVALID = 1'b0;         logic S_AXI_WREADY;
   logic [1:0] S_AXI_BRESP;           logic S_AXI_BVALID; logic S_AXI_BREADY = 1'b0;
   logic [AW-1:0] S_AXI_ARADDR = '0;  logic S_AXI_ARVALID = 1'b0; logic S_AXI_ARREADY;
   logic [DW-1:0] S_AXI_RDATA;        logic [1:0] S_AXI_RRESP;
   logic S_AXI_RVALID;                logic S_AXI_RREADY = 1'b0;
   logic [AW-1:0] wrAddr, rdAddr;     logic [DW-1:0] wrData; logic [SW-1:0] wrStrb;
   logic wr, rd;
   logic wrDone = 1'b0, rdDone = 1'b0;
   logic [DW-1:0] rdData = 32'hDEAD_BEEF;

   axi4lite_responder #(.C_S_AXI_ADDR_WIDTH(AW), .C_S_AXI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
      .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
      .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
      .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .wrAddr(wrAddr), .wrData(wrData), .wrStrb(wrStrb), .wr(wr), .wrDone(wrDone),
      .rdAddr(rdAddr), .rd(rd), .rdData(rdData), .rdDone(rdDone));

   always #5 clk = ~clk;

   typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data; logic [SW-1:0] strb;} wreq_t;
   wreq_t         wreq_q[$];
   logic [AW-1:0] rreq_q[$];
   logic [1:0]    b_q[$];
   logic [DW+1:0] r_q[$];        // {resp, data}
   int            wlat_q[$], rlat_q[$];

   int n_cmp = 0, n_err = 0;
   int wr_delay = 0, rd_delay = 0;
   logic [DW-1:0] rd_value = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Local-bus responders: pulse done a programmed number of cycles after the request rises (-1 = never).
   initial begin
      forever begin
         wait (wr === 1'b1);
         if (wr_delay >= 0) begin
            repeat (wr_delay) tick();
            if (wr === 1'b1) begin wrDone = 1'b1; tick(); wrDone = 1'b0; end
         end
         wait (wr === 1'b0);
      end
   end

   initial begin
      forever begin
         wait (rd === 1'b1);
         if (rd_delay >= 0) begin
            repeat (rd_delay) tick();
            if (rd === 1'b1) begin
               rdData = rd_value; rdDone = 1'b1; tick();
               rdDone = 1'b0; rdData = 32'hDEAD_BEEF;
            end
         end
         wait (rd === 1'b0);
      end
   end

   // Monitor: request capture, response latency, and response payload while valid.
   initial begin
      logic wr_prev = 0, rd_prev = 0, bv_prev = 0, rv_prev = 0;
      int   wcnt = 0, rcnt = 0;
      wreq_t we;
      forever begin
         @(negedge clk);
         if (rst) begin
            wr_prev = 0; rd_prev = 0; bv_prev = 0; rv_prev = 0; wcnt = 0; rcnt = 0;
         end else begin
            wcnt++; rcnt++;
            if (wr && !wr_prev) begin
               wcnt = 0;
               if (wreq_q.size() > 0) begin
                  we = wreq_q.pop_front();
                  check("wrAddr", wrAddr, we.addr);
                  check("wrData", wrData, we.data);
                  check("wrStrb", wrStrb, we.strb);
               end else check("wr_unexpected", wr, 0);
            end
            if (rd && !rd_prev) begin
               rcnt = 0;
               if (rreq_q.size() > 0) check("rdAddr", rdAddr, rreq_q.pop_front());
               else check("rd_unexpected", rd, 0);
            end
            if (S_AXI_BVALID && !bv_prev) begin
               if (wlat_q.size() > 0) check("b_latency", wcnt, wlat_q.pop_front());
               else check("b_unexpected_rise", S_AXI_BVALID, 0);
            end
            if (S_AXI_RVALID && !rv_prev) begin
               if (rlat_q.size() > 0) check("r_latency", rcnt, rlat_q.pop_front());
               else check("r_unexpected_rise", S_AXI_RVALID, 0);
            end
            if (S_AXI_BVALID) begin
               if (b_q.size() > 0) begin
                  check("bresp", S_AXI_BRESP, b_q[0]);
                  if (S_AXI_BREADY) void'(b_q.pop_front());
               end else check("b_unexpected", S_AXI_BVALID, 0);
            end
            if (S_AXI_RVALID) begin
               if (r_q.size() > 0) begin
                  check("rresp_rdata", {S_AXI_RRESP, S_AXI_RDATA}, r_q[0]);
                  if (S_AXI_RREADY) void'(r_q.pop_front());
               end else check("r_unexpected", S_AXI_RVALID, 0);
            end
            wr_prev = wr; rd_prev = rd; bv_prev = S_AXI_BVALID; rv_prev = S_AXI_RVALID;
         end
      end
   end

   task automatic send_aw(input logic [AW-1:0] a);
      bit ok = 0; int n = 0;
      S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
      while (!ok && n < 40) begin ok = S_AXI_AWREADY; tick(); n++; end
      S_AXI_AWVALID = 1'b0;
      check("aw_accept", ok, 1);
   endtask

   task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] s);
      bit ok = 0; int n = 0;
      S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
      while (!ok && n < 40) begin ok = S_AXI_WREADY; tick(); n++; end
      S_AXI_WVALID = 1'b0;
      check("w_accept", ok, 1);
   endtask

   task automatic send_ar(input logic [AW-1:0] a);
      bit ok = 0; int n = 0;
      S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
      while (!ok && n < 40) begin ok = S_AXI_ARREADY; tick(); n++; end
      S_AXI_ARVALID = 1'b0;
      check("ar_accept", ok, 1);
   endtask

   task automatic wait_b();
      bit ok = 0; int n = 0;
      S_AXI_BREADY = 1'b1;
      while (!ok && n < 60) begin ok = S_AXI_BVALID; tick(); n++; end
      S_AXI_BREADY = 1'b0;
      check("b_seen", ok, 1);
   endtask

   task automatic wait_r(input int hold);
      bit ok = 0; int n = 0;
      repeat (hold) tick();
      S_AXI_RREADY = 1'b1;
      while (!ok && n < 60) begin ok = S_AXI_RVALID; tick(); n++; end
      S_AXI_RREADY = 1'b0;
      check("r_seen", ok, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset values.
      repeat (3) tick();
      check("rst_awready", S_AXI_AWREADY, 0);
      check("rst_arready", S_AXI_ARREADY, 0);
      check("rst_bvalid", S_AXI_BVALID, 0);
      check("rst_rvalid", S_AXI_RVALID, 0);
      check("rst_wr_rd", {wr, rd}, 0);
      check("rst_rdata", S_AXI_RDATA, 0);
      rst = 1'b0;
      check("rst_release_ready_low", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
      tick();
      check("ready_after_reset", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

      // AW and W together, done after 2 cycles: wr high 3 cycles.
      wr_delay = 2;
      wreq_q.push_back('{14'h1080, 32'h10, 4'hF}); wlat_q.push_back(3); b_q.push_back(2'b00);
      fork send_aw(14'h1080); send_w(32'd16, 4'hF); join
      check("wr_rise", wr, 1);
      wait_b();
      check("ready_after_b", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);

      // W two cycles ahead of AW.
      wr_delay = 1;
      wreq_q.push_back('{14'h0200, 32'h258, 4'h6}); wlat_q.push_back(2); b_q.push_back(2'b00);
      send_w(32'd600, 4'h6);
      check("w_first_wready", S_AXI_WREADY, 0);
      check("w_first_awready", S_AXI_AWREADY, 1);
      check("w_first_no_wr", wr, 0);
      tick();
      check("w_first_still_no_wr", wr, 0);
      send_aw(14'h0200);
      check("w_first_wr_after_aw", wr, 1);
      wait_b();

      // Read with slow done and a stalled RREADY.
      rd_delay = 4; rd_value = 32'h0000_ABCD;
      rreq_q.push_back(14'h1530); rlat_q.push_back(5); r_q.push_back({2'b00, 32'h0000_ABCD});
      send_ar(14'h1530);
      check("rd_rise", rd, 1);
      repeat (10) tick();
      check("rvalid_held", S_AXI_RVALID, 1);
      wait_r(0);
      check("arready_after_r", S_AXI_ARREADY, 1);

      // Write timeout, then a late done that must be ignored.
      wr_delay = -1;
      wreq_q.push_back('{14'h0008, 32'h1234_5678, 4'h1}); wlat_q.push_back(TO + 1); b_q.push_back(2'b10);
      fork send_aw(14'h0008); send_w(32'h1234_5678, 4'h1); join
      wait_b();
      wrDone = 1'b1; tick(); wrDone = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("late_done_bvalid", {S_AXI_BVALID, wr}, 2'b00);
      end

      // Read timeout: RDATA forced to zero.
      rd_delay = -1;
      rreq_q.push_back(14'h0333); rlat_q.push_back(TO + 1); r_q.push_back({2'b10, 32'h0});
      send_ar(14'h0333);
      wait_r(2);

      // Concurrent write and read with different done delays.
      wr_delay = 5; rd_delay = 1; rd_value = 32'h1234_5678;
      wreq_q.push_back('{14'h0A5C, 32'hA5A5_0F0F, 4'hC}); wlat_q.push_back(6); b_q.push_back(2'b00);
      rreq_q.push_back(14'h2001); rlat_q.push_back(2); r_q.push_back({2'b00, 32'h1234_5678});
      fork
         begin fork send_aw(14'h0A5C); send_w(32'hA5A5_0F0F, 4'hC); join wait_b(); end
         begin send_ar(14'h2001); wait_r(0); end
      join

      // Reset mid W_REQ and mid R_RESP.
      wr_delay = -1; rd_delay = 0; rd_value = 32'h0000_5A5A;
      wreq_q.push_back('{14'h0044, 32'h0000_CAFE, 4'h3});
      rreq_q.push_back(14'h0100); rlat_q.push_back(1); r_q.push_back({2'b00, 32'h0000_5A5A});
      fork send_aw(14'h0044); send_w(32'h0000_CAFE, 4'h3); send_ar(14'h0100); join
      tick(); tick();
      check("pre_reset_wr_rvalid", {wr, S_AXI_RVALID}, 2'b11);
      #2 rst = 1'b1;
      #1;
      check("mid_reset_outputs", {wr, rd, S_AXI_BVALID, S_AXI_RVALID}, 4'b0000);
      check("mid_reset_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
      check("mid_reset_captures", {wrAddr, wrData, rdAddr, S_AXI_RDATA}, 0);
      r_q.delete();
      tick(); tick();
      rst = 1'b0;
      check("reset_release_ready_low", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
      tick();
      check("ready_after_mid_reset", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

      // Normal write after reset, done tied in the same cycle as wr rises.
      wr_delay = 0;
      wreq_q.push_back('{14'h0ABC, 32'h55AA_55AA, 4'hF}); wlat_q.push_back(1); b_q.push_back(2'b00);
      fork send_aw(14'h0ABC); send_w(32'h55AA_55AA, 4'hF); join
      wait_b();
      repeat (3) tick();

      check("pending_wreq", wreq_q.size(), 0);
      check("pending_rreq", rreq_q.size(), 0);
      check("pending_b", b_q.size(), 0);
      check("pending_r", r_q.size(), 0);
      check("pending_lat", wlat_q.size() + rlat_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
